pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Successor to the single-cycle main decoder. Decodes the ID-stage opcode into the control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards (stall) and taken BEQ branches (flush), inserting bubbles.
//  Adds saturating stall/flush counters. Sits between the IF/ID register and the datapath stage registers.
// PARAMETERS
//  REG_ADDR_W  5   register index width (rs1/rs2/rd)
//  CNT_W       16  width of stall/flush event counters (saturating)
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  id_valid       in   1           IF/ID holds a real instruction
//  id_opcode      in   7           instr[6:0]
//  id_rs1         in   REG_ADDR_W  instr[19:15]
//  id_rs2         in   REG_ADDR_W  instr[24:20]
//  id_rd          in   REG_ADDR_W  instr[11:7]
//  ex_zero        in   1           ALU zero flag of instruction now in EX
//  stall          out  1           hold PC and IF/ID; bubble into ID/EX
//  flush          out  1           squash IF/ID; bubble into ID/EX
//  id_illegal     out  1           id_valid & opcode not decoded
//  ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out 1 each  ID/EX controls
//  ex_aluop       out  2           ID/EX ALUOp
//  ex_rd          out  REG_ADDR_W  ID/EX rd
//  mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out 1 each  EX/MEM controls
//  mem_rd         out  REG_ADDR_W  EX/MEM rd
//  wb_memtoreg, wb_regwrite  out 1 each  MEM/WB controls
//  wb_rd          out  REG_ADDR_W  MEM/WB rd
//  stall_cnt, flush_cnt  out  CNT_W  event counters
// BEHAVIOUR
//  - Decode (comb, id_valid=1): ld 0000011: ALUSrc,MemtoReg,RegWrite,MemRead=1, ALUOp 00. sd 0100011: ALUSrc,MemWrite=1, ALUOp 00.
//    R 0110011: RegWrite=1, ALUOp 10. I-ALU 0010011: ALUSrc,RegWrite=1, ALUOp 11. beq 1100011: Branch=1, ALUOp 01.
//  - Unlisted opcode or id_valid=0: all controls 0 (no x). id_illegal = id_valid & unlisted.
//  - rs1 used by all decoded opcodes. rs2 used by R, sd, beq.
//  - stall (comb) = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (rs2 used & ex_rd==id_rs2)) & id_valid.
//  - flush (comb) = ex_branch & ex_zero; flush has priority and forces stall=0.
//  - Each posedge: ID/EX <= (stall|flush|reset) ? bubble(all 0, rd 0) : decode. EX/MEM <= ID/EX subset. MEM/WB <= EX/MEM subset.
//  - Latency: decode visible on ex_* 1 cycle after ID, mem_* 2 cycles, wb_* 3 cycles.
//  - Downstream stages never stall; a bubble advances like any instruction.
//  - Counters: +1 per cycle with stall (resp. flush) high; hold at 2^CNT_W-1.
//  - reset: all stage registers, rd fields and counters <= 0, so stall=flush=0 on the next cycle.
//    Reset mid-stall or mid-flush discards in-flight controls.
// CONFIGURATION
//  CTRL_JUMP_EN defined: decode jal 1101111 (RegWrite=1, Jump=1, rs1/rs2 unused) and jalr 1100111 (ALUSrc,RegWrite,Jump=1, rs1 used).
//    Adds ex_jump output; flush also asserts on ex_jump.
//  CTRL_JUMP_EN undefined: no ex_jump port; 1101111 and 1100111 are illegal (bubble, id_illegal=1).
// TESTING
//  - reset 2 cycles, then add x3 (0110011, rd 3) -> ex_regwrite=1, aluop 10 at +1; mem_regwrite=1 at +2; wb_regwrite=1, wb_rd=3 at +3.
//  - ld x5, then add x6,x5,x1 next cycle -> stall=1 for exactly 1 cycle; ID/EX bubble; stall_cnt=1.
//  - ld x0, then use x0 -> stall=0. ld x5, then sd with rs2=5 -> stall=1.
//  - beq in EX with ex_zero=1 while ld-use condition holds -> flush=1, stall=0, ID/EX bubble, flush_cnt=1.
//  - id_opcode 1111111, id_valid=1 -> id_illegal=1, ex_* all 0 next cycle. CTRL_JUMP_EN: jal -> ex_jump=1 and flush=1 at +1.
//  - CNT_W=2, hold stall condition 5 cycles -> stall_cnt saturates at 3. Assert reset mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode into a control bundle
// and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects
// load-use hazards (stall) and taken BEQ branches (flush), inserts bubbles,
// and keeps saturating stall/flush event counters.
// Optional feature macro: CTRL_JUMP_EN adds jal/jalr decode and ex_jump.
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  output logic                  stall,
  output logic                  flush,
  output logic                  id_illegal,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_memtoreg,
  output logic                  ex_regwrite,
  output logic [1:0]            ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef CTRL_JUMP_EN
  output logic                  ex_jump,
`endif
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  mem_memtoreg,
  output logic                  mem_regwrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_memtoreg,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // ID/EX control packing: {alusrc, branch, memread, memwrite, memtoreg, regwrite, aluop[1:0]}
  logic [7:0]            dec_ctrl;
  logic                  dec_jump;
  logic                  dec_legal;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [REG_ADDR_W-1:0] dec_rd;

  logic [7:0]            ex_ctrl_q, ex_ctrl_d;
  logic                  ex_jump_q, ex_jump_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  // EX/MEM packing: {memread, memwrite, memtoreg, regwrite}
  logic [3:0]            mem_ctrl_q, mem_ctrl_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  // MEM/WB packing: {memtoreg, regwrite}
  logic [1:0]            wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  // Main decoder; an invalid slot or unknown opcode decodes to an all-zero bubble.
  always_comb begin
    dec_ctrl  = 8'b0;
    dec_jump  = 1'b0;
    dec_legal = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        7'b0000011: begin dec_ctrl = 8'b1010_1100; dec_legal = 1'b1; rs1_used = 1'b1; end
        7'b0100011: begin dec_ctrl = 8'b1001_0000; dec_legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        7'b0110011: begin dec_ctrl = 8'b0000_0110; dec_legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        7'b0010011: begin dec_ctrl = 8'b1000_0111; dec_legal = 1'b1; rs1_used = 1'b1; end
        7'b1100011: begin dec_ctrl = 8'b0100_0001; dec_legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
`ifdef CTRL_JUMP_EN
        7'b1101111: begin dec_ctrl = 8'b0000_0100; dec_jump = 1'b1; dec_legal = 1'b1; end
        7'b1100111: begin dec_ctrl = 8'b1000_0100; dec_jump = 1'b1; dec_legal = 1'b1; rs1_used = 1'b1; end
`endif
        default: ;
      endcase
    end
    dec_rd = dec_legal ? id_rd : '0;
  end

  assign id_illegal = id_valid & ~dec_legal;

  // Hazard detection: a taken branch (or jump) flushes and overrides the load-use stall.
  always_comb begin
    flush = ex_ctrl_q[6] & ex_zero;
`ifdef CTRL_JUMP_EN
    flush = flush | ex_jump_q;
`endif
    stall = ~flush & id_valid & ex_ctrl_q[5] & (ex_rd_q != '0) &
            ((rs1_used & (ex_rd_q == id_rs1)) | (rs2_used & (ex_rd_q == id_rs2)));
  end

  // Next-state for stage registers and saturating event counters.
  always_comb begin
    ex_ctrl_d   = dec_ctrl;
    ex_jump_d   = dec_jump;
    ex_rd_d     = dec_rd;
    if (stall | flush) begin
      ex_ctrl_d = 8'b0;
      ex_jump_d = 1'b0;
      ex_rd_d   = '0;
    end
    mem_ctrl_d  = ex_ctrl_q[5:2];
    mem_rd_d    = ex_rd_q;
    wb_ctrl_d   = mem_ctrl_q[1:0];
    wb_rd_d     = mem_rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Pipeline and counter registers; reset discards every in-flight control.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q   <= 8'b0;
      ex_jump_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_ctrl_q  <= 4'b0;
      mem_rd_q    <= '0;
      wb_ctrl_q   <= 2'b0;
      wb_rd_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_jump_q   <= ex_jump_d;
      ex_rd_q     <= ex_rd_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {ex_alusrc, ex_branch, ex_memread, ex_memwrite,
          ex_memtoreg, ex_regwrite, ex_aluop} = ex_ctrl_q;
  assign ex_rd = ex_rd_q;
`ifdef CTRL_JUMP_EN
  assign ex_jump = ex_jump_q;
`else
  logic unused_jump;
  assign unused_jump = ex_jump_q ^ ex_jump_d;
`endif
  assign {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite} = mem_ctrl_q;
  assign mem_rd = mem_rd_q;
  assign {wb_memtoreg, wb_regwrite} = wb_ctrl_q;
  assign wb_rd = wb_rd_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: a driver applies one directed
// vector per cycle and queues its hand-computed expected outputs; a monitor
// pops and compares on the falling edge. A second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [7:0] EX_LD  = 8'hAC;
  localparam logic [7:0] EX_R   = 8'h06;
  localparam logic [7:0] EX_I   = 8'h87;
  localparam logic [7:0] EX_BEQ = 8'h41;
  localparam logic [3:0] MEM_LD = 4'hB;
  localparam logic [3:0] MEM_RW = 4'h1;
  localparam logic [1:0] WB_LD  = 2'b11;
  localparam logic [1:0] WB_RW  = 2'b01;

  typedef struct packed {
    logic        st, fl, il;
    logic [7:0]  ex;
    logic [4:0]  exrd;
    logic [3:0]  mem;
    logic [4:0]  memrd;
    logic [1:0]  wb;
    logic [4:0]  wbrd;
    logic [15:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [6:0] id_opcode = OP_LD;
  logic [4:0] id_rs1 = 5'd5, id_rs2 = 5'd5, id_rd = 5'd5;
  logic ex_zero = 1'b0;

  logic stall, flush, id_illegal;
  logic ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic wb_memtoreg, wb_regwrite;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_stall, s_flush, s_ill;
  logic s_alusrc, s_branch, s_memread, s_memwrite, s_memtoreg, s_regwrite;
  logic [1:0] s_aluop;
  logic [4:0] s_exrd, s_memrd, s_wbrd;
  logic s_mmr, s_mmw, s_mmt, s_mrw, s_wmt, s_wrw;
  logic [1:0] s_scnt, s_fcnt;
`ifdef CTRL_JUMP_EN
  logic ex_jump, s_jump;
`endif

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipelined_control_unit u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(stall), .flush(flush), .id_illegal(id_illegal),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd),
`ifdef CTRL_JUMP_EN
    .ex_jump(ex_jump),
`endif
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(s_stall), .flush(s_flush), .id_illegal(s_ill),
    .ex_alusrc(s_alusrc), .ex_branch(s_branch), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_memtoreg(s_memtoreg), .ex_regwrite(s_regwrite),
    .ex_aluop(s_aluop), .ex_rd(s_exrd),
`ifdef CTRL_JUMP_EN
    .ex_jump(s_jump),
`endif
    .mem_memread(s_mmr), .mem_memwrite(s_mmw),
    .mem_memtoreg(s_mmt), .mem_regwrite(s_mrw), .mem_rd(s_memrd),
    .wb_memtoreg(s_wmt), .wb_regwrite(s_wrw), .wb_rd(s_wbrd),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, req);
    end
  endtask

  // Drive one vector #1 after the rising edge and queue what the monitor should see before the next edge.
  task automatic step(input logic rst, input logic v, input logic [6:0] op,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic z, input logic chk,
                      input logic st, input logic fl, input logic il,
                      input logic [7:0] ex, input logic [4:0] exrd,
                      input logic [3:0] mem, input logic [4:0] memrd,
                      input logic [1:0] wb, input logic [4:0] wbrd,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_opcode = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_zero = z;
    e = '{st, fl, il, ex, exrd, mem, memrd, wb, wbrd, sc, fc};
    if (chk) sb.push_back(e);
  endtask

  // Idle slot: a load encoding with id_valid low, which must never decode or stall.
  task automatic nop(input logic st, input logic fl, input logic il,
                     input logic [7:0] ex, input logic [4:0] exrd,
                     input logic [3:0] mem, input logic [4:0] memrd,
                     input logic [1:0] wb, input logic [4:0] wbrd,
                     input logic [15:0] sc, input logic [15:0] fc);
    step(0, 0, OP_LD, 5, 5, 5, 0, 1, st, fl, il, ex, exrd, mem, memrd, wb, wbrd, sc, fc);
  endtask

  // Dependent load chain: ld x5 with rs1=x5.
  task automatic ldd(input logic rst, input logic st,
                     input logic [7:0] ex, input logic [4:0] exrd,
                     input logic [3:0] mem, input logic [4:0] memrd,
                     input logic [1:0] wb, input logic [4:0] wbrd,
                     input logic [15:0] sc, input logic [15:0] fc);
    step(rst, 1, OP_LD, 5, 0, 5, 0, 1, st, 0, 0, ex, exrd, mem, memrd, wb, wbrd, sc, fc);
  endtask

  // Monitor: every falling edge with a queued expectation is one transaction.
  initial begin : monitor
    exp_t e;
    int row;
    logic [15:0] sat;
    row = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        row++;
        check("stall", row, {31'b0, stall}, {31'b0, e.st});
        check("flush", row, {31'b0, flush}, {31'b0, e.fl});
        check("id_illegal", row, {31'b0, id_illegal}, {31'b0, e.il});
        check("ex_ctrl", row, {24'b0, ex_alusrc, ex_branch, ex_memread, ex_memwrite,
                               ex_memtoreg, ex_regwrite, ex_aluop}, {24'b0, e.ex});
        check("ex_rd", row, {27'b0, ex_rd}, {27'b0, e.exrd});
        check("mem_ctrl", row, {28'b0, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite},
              {28'b0, e.mem});
        check("mem_rd", row, {27'b0, mem_rd}, {27'b0, e.memrd});
        check("wb_ctrl", row, {30'b0, wb_memtoreg, wb_regwrite}, {30'b0, e.wb});
        check("wb_rd", row, {27'b0, wb_rd}, {27'b0, e.wbrd});
        check("stall_cnt", row, {16'b0, stall_cnt}, {16'b0, e.sc});
        check("flush_cnt", row, {16'b0, flush_cnt}, {16'b0, e.fc});
        sat = (e.sc > 16'd3) ? 16'd3 : e.sc;
        check("sat_stall_cnt", row, {30'b0, s_scnt}, {16'b0, sat});
        $display("row %0d: stall=%0b flush=%0b ill=%0b ex=%02h/%0d mem=%01h/%0d wb=%01h/%0d cnt=%0d/%0d",
                 row, stall, flush, id_illegal,
                 {ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_aluop},
                 ex_rd, {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite}, mem_rd,
                 {wb_memtoreg, wb_regwrite}, wb_rd, stall_cnt, flush_cnt);
      end
    end
  end

  // Driver: directed program with hand-computed expectations per cycle.
  initial begin : driver
    step(1, 0, OP_LD, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, OP_LD, 5, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add x3: pipeline latency through ex/mem/wb
    step(0, 1, OP_R, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, EX_R, 3, 0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0, MEM_RW, 3, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0, 0, 0, WB_RW, 3, 0, 0);
    // ld x5 then add x6,x5,x1: one-cycle stall, bubble in ID/EX
    step(0, 1, OP_LD, 2, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 0, 1, 1, 0, 0, EX_LD, 5, 0, 0, 0, 0, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 0, 1, 0, 0, 0, 0, 0, MEM_LD, 5, 0, 0, 1, 0);
    nop(0, 0, 0, EX_R, 6, 0, 0, WB_LD, 5, 1, 0);
    // ld x0 then use x0: no stall
    step(0, 1, OP_LD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, MEM_RW, 6, 0, 0, 1, 0);
    step(0, 1, OP_R, 0, 0, 7, 0, 1, 0, 0, 0, EX_LD, 0, 0, 0, WB_RW, 6, 1, 0);
    // ld x5 then sd with rs2=x5: stall through rs2
    step(0, 1, OP_LD, 1, 0, 5, 0, 1, 0, 0, 0, EX_R, 7, MEM_LD, 0, 0, 0, 1, 0);
    step(0, 1, OP_SD, 1, 5, 0, 0, 1, 1, 0, 0, EX_LD, 5, MEM_RW, 7, WB_LD, 0, 1, 0);
    nop(0, 0, 0, 0, 0, MEM_LD, 5, WB_RW, 7, 2, 0);
    // beq taken in EX: flush beats the dependent add in ID
    step(0, 1, OP_BEQ, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, WB_LD, 5, 2, 0);
    step(0, 1, OP_R, 5, 1, 6, 1, 1, 0, 1, 0, EX_BEQ, 0, 0, 0, 0, 0, 2, 0);
    nop(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    // illegal opcode decodes to a bubble; then an I-type ALU op
    step(0, 1, OP_BAD, 5, 0, 9, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1);
    step(0, 1, OP_I, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    nop(0, 0, 0, EX_I, 4, 0, 0, 0, 0, 2, 1);
    nop(0, 0, 0, 0, 0, MEM_RW, 4, 0, 0, 2, 1);
    nop(0, 0, 0, 0, 0, 0, 0, WB_RW, 4, 2, 1);
    // dependent load chain: stall every other cycle, CNT_W=2 copy saturates
    ldd(0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    ldd(0, 1, EX_LD, 5, 0, 0, 0, 0, 2, 1);
    ldd(0, 0, 0, 0, MEM_LD, 5, 0, 0, 3, 1);
    ldd(0, 1, EX_LD, 5, 0, 0, WB_LD, 5, 3, 1);
    ldd(0, 0, 0, 0, MEM_LD, 5, 0, 0, 4, 1);
    ldd(0, 1, EX_LD, 5, 0, 0, WB_LD, 5, 4, 1);
    ldd(0, 0, 0, 0, MEM_LD, 5, 0, 0, 5, 1);
    // reset asserted while stall is high clears everything on the next cycle
    ldd(1, 1, EX_LD, 5, 0, 0, WB_LD, 5, 5, 1);
    ldd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, EX_LD, 5, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
